// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// Optional subtract control (sub) is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// {cout,sum} = a + b + cin after WIDTH RUN cycles; start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a sub input (a - b, cout = no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             done_q;
  logic             busy_q;

  logic             sub_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;
  logic             fs_s;
  logic             fc_s;
  logic [WIDTH-1:0] acc_d;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s = bus.sub;
`else
  assign sub_s = 1'b0;
`endif

  // Operand conditioning at load: subtract is a + ~b + 1.
  always_comb begin
    b_load_s = bus.b;
    c_load_s = bus.cin;
    if (sub_s) begin
      b_load_s = ~bus.b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = bus.b;
      c_load_s = bus.cin;
    end
  end

  // Single full-adder cell on the current LSBs; result bit enters at the MSB.
  always_comb begin
    fs_s  = sa_q[0] ^ sb_q[0] ^ carry_q;
    fc_s  = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    // Shifting {fs, acc} right keeps this legal for WIDTH=1 as well.
    acc_d = WIDTH'({fs_s, acc_q} >> 1);
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= b_load_s;
            carry_q <= c_load_s;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          acc_q   <= acc_d;
          carry_q <= fc_s;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= fc_s;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // busy lags the RUN state by one edge and drops on the final edge.
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
